// File: rtl/lab2_stim_checker_if.sv
// Signal bundle between lab2_stim_checker (slave) and whatever drives/observes it (master).
// Handshake: start is a level request sampled only while idle; done is a one-cycle pulse and
// err_count/glitch_count/pass hold their values until the next accepted start.
interface lab2_stim_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             dut_out;
    logic             in1;
    logic             in2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] glitch_count;
    logic [1:0]       vec_idx;
    logic [1:0]       dbg_state;

    modport master (
        output start,
        output dut_out,
        input  in1,
        input  in2,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  glitch_count,
        input  vec_idx,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  dut_out,
        output in1,
        output in2,
        output busy,
        output done,
        output pass,
        output err_count,
        output glitch_count,
        output vec_idx,
        output dbg_state
    );
endinterface

// File: rtl/lab2_stim_checker.sv
// Gray-order stimulus generator and settled-value checker for the delay-circuit experiment.
// Optional macro GLITCH_CHK_EN adds edge counting inside the check windows.
module lab2_stim_checker #(
    parameter int         HOLD_CYCLES   = 8,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] EXPECT_MAP    = 4'b1111,
    parameter int         LOOPS         = 1,
    parameter int         CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    lab2_stim_checker_if.slave bus
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CW-1:0]    APPLY_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    CHECK_LAST = CW'(HOLD_CYCLES - SETTLE_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_LAST  = LW'(LOOPS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_step;
    logic [LW-1:0]    r_loop;
    logic [1:0]       r_vec;
    logic             r_s1;
    logic             r_ds;
    logic [CNT_W-1:0] r_err;
    logic             r_pass;

    logic w_start_acc;
    logic w_last_apply;
    logic w_last_check;
    logic w_last_vec;
    logic w_err_hit;
    logic w_glitch_zero;

    // Step position 0..3 maps to {in1,in2} = 00, 01, 11, 10.
    function automatic logic [1:0] gray_of(input logic [1:0] step);
        return {step[1], step[1] ^ step[0]};
    endfunction

    assign w_start_acc  = (r_state == S_IDLE) && bus.start;
    assign w_last_apply = (r_cnt == APPLY_LAST);
    assign w_last_check = (r_cnt == CHECK_LAST);
    assign w_last_vec   = (r_step == 2'd3) && (r_loop == LOOP_LAST);
    assign w_err_hit    = (r_state == S_CHECK) && w_last_check && (r_ds != EXPECT_MAP[r_vec]);

    // dut_out is asynchronous to clk; nothing downstream looks at it before r_ds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_ds <= 1'b0;
        end else begin
            r_s1 <= bus.dut_out;
            r_ds <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_APPLY;
            S_APPLY: if (w_last_apply) w_next = S_CHECK;
            S_CHECK: if (w_last_check) w_next = w_last_vec ? S_DONE : S_APPLY;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_step <= 2'd0;
            r_loop <= '0;
            r_vec  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= '0;
                        r_step <= 2'd0;
                        r_loop <= '0;
                        r_vec  <= 2'b00;
                    end
                end
                S_APPLY: begin
                    r_cnt <= w_last_apply ? '0 : r_cnt + 1'b1;
                end
                S_CHECK: begin
                    r_cnt <= w_last_check ? '0 : r_cnt + 1'b1;
                    if (w_last_check) begin
                        if (w_last_vec) begin
                            r_step <= 2'd0;
                            r_loop <= '0;
                            r_vec  <= 2'b00;
                        end else begin
                            // Step 3 -> 0 wraps 10 -> 00, still a single-bit change.
                            r_step <= r_step + 2'd1;
                            r_vec  <= gray_of(r_step + 2'd1);
                            if (r_step == 2'd3) r_loop <= r_loop + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_vec <= 2'b00;
                end
                default: begin
                    r_vec <= 2'b00;
                end
            endcase
        end
    end

`ifdef GLITCH_CHK_EN
    logic             r_ds_prev;
    logic [CNT_W-1:0] r_glitch;
    logic             w_glitch_hit;

    // The first check cycle only serves as the reference value, so an edge landing
    // exactly on the window boundary is not counted.
    assign w_glitch_hit = (r_state == S_CHECK) && (r_cnt != '0) && (r_ds != r_ds_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ds_prev <= 1'b0;
            r_glitch  <= '0;
        end else begin
            r_ds_prev <= r_ds;
            if (w_start_acc) begin
                r_glitch <= '0;
            end else if (w_glitch_hit && (r_glitch != CNT_MAX)) begin
                r_glitch <= r_glitch + 1'b1;
            end
        end
    end

    assign w_glitch_zero    = (r_glitch == '0);
    assign bus.glitch_count = r_glitch;
`else
    assign w_glitch_zero    = 1'b1;
    assign bus.glitch_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (w_start_acc) begin
            r_err  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_err_hit && (r_err != CNT_MAX)) r_err <= r_err + 1'b1;
            if (r_state == S_DONE) r_pass <= (r_err == '0) && w_glitch_zero;
        end
    end

    assign bus.in1       = r_vec[1];
    assign bus.in2       = r_vec[0];
    assign bus.vec_idx   = r_vec;
    assign bus.busy      = (r_state == S_APPLY) || (r_state == S_CHECK);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.dbg_state = r_state;
endmodule
